// File: rtl/bus_arbiter3_if.sv
// Bus bundle between the three requesting masters and the bus_arbiter3 sequencer.
// The arbiter uses the slave modport; the master modport drives requests and data.
interface bus_arbiter3_if;
   logic [2:0]  req;
   logic [15:0] din0;
   logic [15:0] din1;
   logic [15:0] din2;
   logic [2:0]  gnt;
   logic [1:0]  sel;
   logic [2:0]  ack;
   logic [15:0] dout;
   logic        dout_valid;
   logic        dout_ready;

   modport slave (
      input  req, din0, din1, din2, dout_ready,
      output gnt, sel, ack, dout, dout_valid
   );

   modport master (
      output req, din0, din1, din2, dout_ready,
      input  gnt, sel, ack, dout, dout_valid
   );
endinterface

// File: rtl/bus_arbiter3.sv
// Round-robin arbiter/sequencer for the shared 16-bit three-master datapath port.
// Define BUS_ARBITER3_BURST_LIMIT_EN to force rotation after MAX_BURST accepted beats.
module bus_arbiter3 #(
   parameter int unsigned MAX_BURST = 4
) (
   input  logic           clk,
   input  logic           reset_n,
   bus_arbiter3_if.slave  bus
);

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t     state_q, state_d;
   logic [1:0] sel_q, sel_d;
   logic [1:0] last_q, last_d;
   logic [3:0] req_ext;
   logic       owner_req;
   logic       accept;
   logic       release_now;
   logic [2:0] pick_idle;
   logic [2:0] pick_rel;

`ifdef BUS_ARBITER3_BURST_LIMIT_EN
   logic [3:0] cnt_q, cnt_d;
`endif

   // MAX_BURST must fit the 4-bit beat counter.
   if (MAX_BURST == 0 || MAX_BURST > 15) begin : g_max_burst_out_of_range
   end

   // Returns {found, index}: first requester searched upward from prev+1 (mod 3).
   function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] prev);
      logic [2:0] res;
      int         j;
      res = 3'b000;
      for (int k = 3; k >= 1; k--) begin
         j = (int'(prev) + k) % 3;
         if (req[j]) res = {1'b1, 2'(j)};
      end
      return res;
   endfunction

   always_comb begin
      req_ext     = {1'b0, bus.req};
      owner_req   = (state_q == S_GRANT) && req_ext[sel_q];
      accept      = owner_req && bus.dout_ready;
      release_now = (state_q == S_GRANT) && !req_ext[sel_q];
`ifdef BUS_ARBITER3_BURST_LIMIT_EN
      release_now = release_now || (accept && (cnt_q == 4'(MAX_BURST - 1)));
`endif
      pick_idle   = rr_pick(bus.req, last_q);
      pick_rel    = rr_pick(bus.req, sel_q);

      bus.dout_valid = owner_req;
      bus.ack        = accept ? (3'b001 << sel_q) : 3'b000;
      bus.gnt        = (state_q == S_GRANT) ? (3'b001 << sel_q) : 3'b000;
      bus.sel        = sel_q;
      bus.dout       = 16'h0000;
      if (state_q == S_GRANT) begin
         case (sel_q)
            2'd0:    bus.dout = bus.din0;
            2'd1:    bus.dout = bus.din1;
            2'd2:    bus.dout = bus.din2;
            default: bus.dout = 16'h0000;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      last_d  = last_q;
`ifdef BUS_ARBITER3_BURST_LIMIT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (pick_idle[2]) begin
               state_d = S_GRANT;
               sel_d   = pick_idle[1:0];
            end
         end
         S_GRANT: begin
            if (release_now) begin
               last_d = sel_q;
`ifdef BUS_ARBITER3_BURST_LIMIT_EN
               cnt_d  = 4'd0;
`endif
               // Handover goes straight to the next owner so no bubble appears.
               if (pick_rel[2]) begin
                  sel_d = pick_rel[1:0];
               end else begin
                  state_d = S_IDLE;
                  sel_d   = 2'd0;
               end
            end
`ifdef BUS_ARBITER3_BURST_LIMIT_EN
            else if (accept) begin
               cnt_d = cnt_q + 4'd1;
            end
`endif
         end
         default: begin
            state_d = S_IDLE;
            sel_d   = 2'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         sel_q   <= 2'd0;
         last_q  <= 2'd2;
`ifdef BUS_ARBITER3_BURST_LIMIT_EN
         cnt_q   <= 4'd0;
`endif
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
`ifdef BUS_ARBITER3_BURST_LIMIT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_bus_arbiter3.sv
// Randomized plus directed bench for bus_arbiter3 with a queue-based scoreboard
// fed by a cycle-level reference model of the round-robin rules.
module tb_bus_arbiter3;

   localparam int MAXB = 4;

   typedef struct packed {
      logic [2:0]  gnt;
      logic [1:0]  sel;
      logic [2:0]  ack;
      logic [15:0] dout;
      logic        valid;
   } obs_t;

   logic clk;
   logic reset_n;
   bus_arbiter3_if bus ();

   bus_arbiter3 #(.MAX_BURST(MAXB)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   obs_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   logic fix_beef = 1'b0;

   // Reference model: owner -1 means nobody holds the port.
   int m_owner = -1;
   int m_last  = 2;
   int m_count = 0;

   function automatic int next_owner(input logic [2:0] r, input int from);
      for (int k = 1; k <= 3; k++) begin
         if (r[(from + k) % 3]) return (from + k) % 3;
      end
      return -1;
   endfunction

   function automatic logic [15:0] din_of(input int idx);
      if (idx == 0) return bus.din0;
      if (idx == 1) return bus.din1;
      return bus.din2;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_last  = 2;
      m_count = 0;
   endtask

   task automatic model_step();
      bit give_up;
      if (!reset_n) begin
         model_reset();
      end else if (m_owner < 0) begin
         m_owner = next_owner(bus.req, m_last);
      end else begin
         if (bus.req[m_owner] && bus.dout_ready) m_count++;
         give_up = !bus.req[m_owner];
`ifdef BUS_ARBITER3_BURST_LIMIT_EN
         if (m_count >= MAXB) give_up = 1'b1;
`endif
         if (give_up) begin
            m_last  = m_owner;
            m_count = 0;
            m_owner = next_owner(bus.req, m_last);
         end
      end
   endtask

   function automatic obs_t model_out();
      obs_t o;
      o = '0;
      if (m_owner >= 0) begin
         o.gnt   = 3'(1 << m_owner);
         o.sel   = 2'(m_owner);
         o.dout  = din_of(m_owner);
         o.valid = bus.req[m_owner];
         o.ack   = (o.valid && bus.dout_ready) ? o.gnt : 3'b000;
      end
      return o;
   endfunction

   task automatic cycle(input logic [2:0] r, input logic rdy, input logic rstn, input logic mid_rst);
      @(posedge clk);
      model_step();
      #1;
      bus.req        = r;
      bus.dout_ready = rdy;
      bus.din0       = 16'($urandom);
      bus.din1       = fix_beef ? 16'hBEEF : 16'($urandom);
      bus.din2       = 16'($urandom);
      reset_n        = rstn;
      if (!rstn) model_reset();
      if (mid_rst) begin
         #2;
         reset_n = 1'b0;
         model_reset();
      end
      exp_q.push_back(model_out());
   endtask

   task automatic repeat_cycle(input int n, input logic [2:0] r, input logic rdy);
      for (int i = 0; i < n; i++) cycle(r, rdy, 1'b1, 1'b0);
   endtask

   // Monitor: compares every presented output cycle against the scoreboard.
   initial begin
      obs_t e, a;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bus.gnt, bus.sel, bus.ack, bus.dout, bus.dout_valid};
            n_checks++;
            if (a === e) begin
               n_pass++;
            end else begin
               $display("FAIL outputs @%0t: got gnt=%b sel=%b ack=%b dout=%h valid=%b, want gnt=%b sel=%b ack=%b dout=%h valid=%b",
                        $time, a.gnt, a.sel, a.ack, a.dout, a.valid,
                        e.gnt, e.sel, e.ack, e.dout, e.valid);
            end
            $display("cycle @%0t req=%b rdy=%b rst_n=%b gnt=%b sel=%0d ack=%b dout=%h valid=%b",
                     $time, bus.req, bus.dout_ready, reset_n, a.gnt, a.sel, a.ack, a.dout, a.valid);
         end
      end
   end

   initial begin
      logic [2:0] r;
      logic       rdy, rstn;
      reset_n        = 1'b0;
      bus.req        = 3'b000;
      bus.dout_ready = 1'b0;
      bus.din0       = 16'h0;
      bus.din1       = 16'h0;
      bus.din2       = 16'h0;

      // Reset held with all masters requesting, then release.
      for (int i = 0; i < 3; i++) cycle(3'b111, 1'b1, 1'b0, 1'b0);
      repeat_cycle(4, 3'b111, 1'b1);
      repeat_cycle(2, 3'b000, 1'b1);

      // Single master with a fixed data word.
      fix_beef = 1'b1;
      repeat_cycle(5, 3'b010, 1'b1);
      fix_beef = 1'b0;
      repeat_cycle(3, 3'b000, 1'b1);

      // Two masters contending: burst rotation or hold depending on build.
      repeat_cycle(20, 3'b011, 1'b1);
      repeat_cycle(6, 3'b010, 1'b1);
      repeat_cycle(2, 3'b000, 1'b1);

      // Stall on owner 2.
      repeat_cycle(2, 3'b100, 1'b1);
      repeat_cycle(3, 3'b100, 1'b0);
      repeat_cycle(2, 3'b100, 1'b1);
      repeat_cycle(1, 3'b000, 1'b1);

      // Asynchronous reset asserted between edges during beat 2.
      repeat_cycle(2, 3'b001, 1'b1);
      cycle(3'b001, 1'b1, 1'b1, 1'b1);
      repeat_cycle(6, 3'b011, 1'b1);

      // Randomized traffic with occasional resets.
      r = 3'b000;
      for (int i = 0; i < 400; i++) begin
         for (int b = 0; b < 3; b++) begin
            if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
         end
         rdy  = ($urandom_range(0, 3) != 0);
         rstn = ($urandom_range(0, 99) != 0);
         cycle(r, rdy, rstn, 1'b0);
      end

      @(negedge clk);
      #1;
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
